// File: rtl/magic_buttons.sv
`timescale 1ns/1ps
// MAGIC push-button conditioning (sync, debounce, short/long press) merged with
// keyboard MAGIC/PAUSE pulses into frame-aligned held request levels.
module magic_buttons #(
  parameter int DEBOUNCE_CYCLES = 280000,
  parameter int LONG_FRAMES     = 100,
  parameter int HOLD_FRAMES     = 2
) (
  input  logic rst_n,
  input  logic clk28,
  input  logic btn_n,
  input  logic kbd_magic,
  input  logic kbd_pause,
  input  logic n_int,
  output logic magic_button,
  output logic pause_button,
  output logic reboot_req,
  output logic long_hold
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LF_W = $clog2(LONG_FRAMES + 1);
  localparam int HF_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LF_W-1:0] LF_LAST = LF_W'(LONG_FRAMES - 1);
  localparam logic [LF_W-1:0] LF_MAX  = LF_W'(LONG_FRAMES);
  localparam logic [HF_W-1:0] HF_LOAD = HF_W'(HOLD_FRAMES);
  localparam logic [HF_W-1:0] HF_ONE  = HF_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG} state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            w_btn_s;
  logic            r_btn_db;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_n_int_d;
  logic            w_frame;
  state_t          r_state;
  state_t          w_state_next;
  logic [LF_W-1:0] r_frame_cnt;
  logic [LF_W-1:0] w_frame_cnt_next;
  logic            w_short;
  logic            w_reboot;
  logic            r_reboot;
  logic [1:0]      w_trig;
  logic [1:0]      w_req;

  // Synchronisers reset to the released (high) level of the active-low button.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = ~r_sync2;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_btn_s != r_btn_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_btn_db <= w_btn_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) r_n_int_d <= 1'b1;
    else        r_n_int_d <= n_int;
  end

  assign w_frame = r_n_int_d & ~n_int;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_reboot    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_reboot    <= w_reboot;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_short          = 1'b0;
    w_reboot         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_btn_db) begin
          w_state_next     = S_PRESSED;
          w_frame_cnt_next = '0;
        end
      end
      S_PRESSED: begin
        // Release before the long threshold is a short press.
        if (!r_btn_db) begin
          w_short      = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_frame) begin
          if (r_frame_cnt >= LF_LAST) begin
            w_frame_cnt_next = LF_MAX;
            w_reboot         = 1'b1;
            w_state_next     = S_LONG;
          end else begin
            w_frame_cnt_next = r_frame_cnt + 1'b1;
          end
        end
      end
      S_LONG: begin
        if (!r_btn_db) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_trig = {kbd_pause, w_short | kbd_magic};

  // Index 0 is MAGIC, index 1 is PAUSE; a trigger always beats a frame decrement.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic            r_req;
      logic [HF_W-1:0] r_hold;

      always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
          r_req  <= 1'b0;
          r_hold <= '0;
        end else if (w_trig[gi]) begin
          r_req  <= 1'b1;
          r_hold <= HF_LOAD;
        end else if (w_frame && r_req) begin
          r_hold <= r_hold - 1'b1;
          if (r_hold == HF_ONE) r_req <= 1'b0;
        end
      end

      assign w_req[gi] = r_req;
    end
  endgenerate

  assign magic_button = w_req[0];
  assign pause_button = w_req[1];
  assign reboot_req   = r_reboot;
  assign long_hold    = (r_state == S_LONG);

endmodule

// File: tb/tb_magic_buttons.sv
`timescale 1ns/1ps
// Bench for magic_buttons: keyboard request timing table plus button press,
// long press, reset and glitch sequences; output pulses checked against queues.
module tb_magic_buttons;

  logic rst_n;
  logic clk28;
  logic btn_n;
  logic kbd_magic;
  logic kbd_pause;
  logic n_int;
  logic magic_button;
  logic pause_button;
  logic reboot_req;
  logic long_hold;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int n_rises  = 0;

  typedef struct {
    int rise;
    int fall;
  } ev_t;

  typedef struct {
    bit km;
    bit kp;
    int phase;
    int rise_d;
    int fall_d;
  } vec_t;

  ev_t   q_magic[$];
  ev_t   q_pause[$];
  ev_t   q_reboot[$];
  ev_t   q_long[$];
  vec_t  vecs[7];
  string onames[4];
  logic [3:0] mon_prev = '0;
  logic [3:0] mon_now;
  int    rise_t[4];

  magic_buttons #(
    .DEBOUNCE_CYCLES(8),
    .LONG_FRAMES    (4),
    .HOLD_FRAMES    (2)
  ) dut (
    .rst_n       (rst_n),
    .clk28       (clk28),
    .btn_n       (btn_n),
    .kbd_magic   (kbd_magic),
    .kbd_pause   (kbd_pause),
    .n_int       (n_int),
    .magic_button(magic_button),
    .pause_button(pause_button),
    .reboot_req  (reboot_req),
    .long_hold   (long_hold)
  );

  initial begin
    clk28 = 1'b0;
    forever #18 clk28 = ~clk28;
  end

  always @(posedge clk28) cyc <= cyc + 1;

  // n_int low for 4 cycles each 100; the DUT sees a falling edge at cycles 97 mod 100.
  initial begin
    n_int = 1'b1;
    forever begin
      @(negedge clk28);
      n_int = ((cyc % 100) < 96);
    end
  end

  function automatic int outs();
    return int'({long_hold, reboot_req, pause_button, magic_button});
  endfunction

  function automatic int frame_after(input int x, input int n);
    int e;
    e = x - (x % 100) + 97;
    if (e <= x) e += 100;
    return e + (n - 1) * 100;
  endfunction

  task automatic push(input int k, input int r, input int f);
    ev_t e;
    e.rise = r;
    e.fall = f;
    case (k)
      0:       q_magic.push_back(e);
      1:       q_pause.push_back(e);
      2:       q_reboot.push_back(e);
      default: q_long.push_back(e);
    endcase
  endtask

  task automatic check_event(input int k, input int r, input int f);
    ev_t e;
    bit  empty;
    empty = 1'b0;
    case (k)
      0:       if (q_magic.size() == 0) empty = 1'b1; else e = q_magic.pop_front();
      1:       if (q_pause.size() == 0) empty = 1'b1; else e = q_pause.pop_front();
      2:       if (q_reboot.size() == 0) empty = 1'b1; else e = q_reboot.pop_front();
      default: if (q_long.size() == 0) empty = 1'b1; else e = q_long.pop_front();
    endcase
    n_checks++;
    if (empty) begin
      n_fail++;
      $display("FAIL %s: unexpected pulse rise=%0d fall=%0d, required none", onames[k], r, f);
    end else if (e.rise != r || e.fall != f) begin
      n_fail++;
      $display("FAIL %s: rise=%0d fall=%0d, required rise=%0d fall=%0d",
               onames[k], r, f, e.rise, e.fall);
    end else begin
      $display("ok   %s: rise=%0d fall=%0d", onames[k], r, f);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Output monitor: records each rising edge, pops and compares on the falling edge.
  initial begin
    forever begin
      @(negedge clk28);
      mon_now = {long_hold, reboot_req, pause_button, magic_button};
      for (int k = 0; k < 4; k++) begin
        if (mon_now[k] && !mon_prev[k]) begin
          rise_t[k] = cyc;
          n_rises++;
        end else if (!mon_now[k] && mon_prev[k]) begin
          check_event(k, rise_t[k], cyc);
        end
      end
      mon_prev = mon_now;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic wait_phase(input int p);
    @(negedge clk28);
    while ((cyc % 100) != p) @(negedge clk28);
  endtask

  task automatic wait_until(input int t);
    @(negedge clk28);
    while (cyc < t) @(negedge clk28);
  endtask

  task automatic kbd_pulse(input bit m, input bit p);
    kbd_magic = m;
    kbd_pause = p;
    @(negedge clk28);
    kbd_magic = 1'b0;
    kbd_pause = 1'b0;
  endtask

  initial begin
    int c;
    int L;
    int H;
    int F4;
    int X;
    int Y;
    int n0;

    onames[0] = "magic_button";
    onames[1] = "pause_button";
    onames[2] = "reboot_req";
    onames[3] = "long_hold";
    // {kbd_magic, kbd_pause, drive phase, rise delay, fall delay}
    vecs[0] = '{1'b1, 1'b0, 10, 1, 187};
    vecs[1] = '{1'b0, 1'b1, 10, 1, 187};
    vecs[2] = '{1'b1, 1'b1, 10, 1, 187};
    vecs[3] = '{1'b1, 1'b0, 96, 1, 201};
    vecs[4] = '{1'b0, 1'b1, 95, 1, 102};
    vecs[5] = '{1'b1, 1'b0, 97, 1, 200};
    vecs[6] = '{1'b0, 1'b1, 96, 1, 201};

    rst_n     = 1'b1;
    btn_n     = 1'b1;
    kbd_magic = 1'b0;
    kbd_pause = 1'b0;
    #5 rst_n  = 1'b0;
    wait_cycles(3);
    check_val("reset_outputs", outs(), 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wait_phase(vecs[i].phase);
      c = cyc;
      if (vecs[i].km) push(0, c + vecs[i].rise_d, c + vecs[i].fall_d);
      if (vecs[i].kp) push(1, c + vecs[i].rise_d, c + vecs[i].fall_d);
      kbd_pulse(vecs[i].km, vecs[i].kp);
      wait_cycles(vecs[i].fall_d + 4);
    end

    // Pause retrigger just before the first frame edge.
    wait_phase(10);
    c = cyc;
    push(1, c + 1, c + 187);
    kbd_pulse(1'b0, 1'b1);
    wait_cycles(84);
    kbd_pulse(1'b0, 1'b1);
    wait_cycles(110);

    // Pause retrigger after one frame has been consumed: hold extended, no gap.
    wait_phase(10);
    c = cyc;
    push(1, c + 1, c + 287);
    kbd_pulse(1'b0, 1'b1);
    wait_cycles(139);
    kbd_pulse(1'b0, 1'b1);
    wait_cycles(150);

    // Bouncy press followed by a clean hold and release: short press.
    wait_phase(5);
    L = cyc + 30;
    H = L + 20;
    push(0, H + 11, frame_after(H + 11, 2));
    for (int i = 0; i < 30; i++) begin
      btn_n = (((i / 3) % 2) == 1);
      @(negedge clk28);
    end
    btn_n = 1'b0;
    wait_cycles(20);
    btn_n = 1'b1;
    wait_until(frame_after(H + 11, 2) + 5);

    // Short press coinciding with kbd_magic gives a single request.
    wait_phase(5);
    L = cyc;
    H = L + 20;
    push(0, H + 11, frame_after(H + 11, 2));
    btn_n = 1'b0;
    wait_cycles(20);
    btn_n = 1'b1;
    wait_cycles(10);
    kbd_pulse(1'b1, 1'b0);
    wait_until(frame_after(H + 11, 2) + 5);

    // Long press: reboot pulse at 4th frame edge after debounce, long_hold until release.
    wait_phase(5);
    L  = cyc;
    F4 = frame_after(L + 10, 4);
    push(2, F4, F4 + 1);
    push(3, F4, L + 611);
    btn_n = 1'b0;
    wait_cycles(600);
    btn_n = 1'b1;
    wait_until(L + 620);

    // Reset during LONG with the button held, then re-debounce and a fresh long press.
    wait_phase(5);
    L  = cyc;
    F4 = frame_after(L + 10, 4);
    push(2, F4, F4 + 1);
    btn_n = 1'b0;
    wait_until(F4 + 20);
    X = cyc;
    push(3, F4, X + 1);
    #2 rst_n = 1'b0;
    #1 check_val("async_reset_outputs", outs(), 0);
    wait_phase(5);
    Y = cyc;
    #2 rst_n = 1'b1;
    F4 = frame_after(Y + 10, 4);
    push(2, F4, F4 + 1);
    push(0, F4, F4 + 200);
    wait_until(F4 - 1);
    kbd_pulse(1'b1, 1'b0);
    wait_until(Y + 600);
    push(3, F4, Y + 611);
    btn_n = 1'b1;
    wait_until(Y + 620);

    // Glitch shorter than the debounce window.
    wait_phase(5);
    n0    = n_rises;
    btn_n = 1'b0;
    wait_cycles(5);
    btn_n = 1'b1;
    wait_cycles(40);
    check_val("glitch_no_events", n_rises - n0, 0);
    check_val("glitch_outputs", outs(), 0);

    wait_cycles(5);
    check_val("magic_pending", q_magic.size(), 0);
    check_val("pause_pending", q_pause.size(), 0);
    check_val("reboot_pending", q_reboot.size(), 0);
    check_val("long_pending", q_long.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
